// File: rtl/ccmp_out_packer.sv
// CCMP output byte-to-word packer: assembles little-endian 32-bit words with
// byte enables from the CCMP byte stream and queues them for the MAC FIFO writer.
// Ports: macCoreClk/macCoreClkHardRst_n clock and async reset; ccmpOut*Mux byte
// stream in; flush_p abort; wordData/wordBe/wordLast/wordValid/wordReady word
// handshake out; packerOverflow sticky drop flag; packerIdle registered idle.
module ccmp_out_packer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        macCoreClk,
  input  logic        macCoreClkHardRst_n,
  input  logic [7:0]  ccmpOutDataMux,
  input  logic        ccmpOutValidMux_p,
  input  logic        ccmpOutLastMux_p,
  input  logic        flush_p,
  input  logic        wordReady,
  output logic [31:0] wordData,
  output logic [3:0]  wordBe,
  output logic        wordLast,
  output logic        wordValid,
  output logic        packerOverflow,
  output logic        packerIdle
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        last;
    logic [3:0]  be;
    logic [31:0] data;
  } word_t;

  logic [23:0]   acc;
  logic [1:0]    lane;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf_q;
  logic          idle_q;
  word_t         mem [FIFO_DEPTH];
  word_t         head;

  logic          in_valid;
  logic          in_last;
  logic          push;
  logic [2:0]    n_bytes;
  logic [3:0]    be_new;
  logic [31:0]   raw;
  word_t         word_in;
  logic          full;
  logic          do_pop;
  logic          do_wr;
  logic          drop;
  logic [1:0]    lane_nxt;
  logic [CW-1:0] count_nxt;

  // Flush discards anything arriving in the same cycle.
  always_comb begin
    in_valid = ccmpOutValidMux_p & ~flush_p;
    in_last  = ccmpOutLastMux_p & ~flush_p;
    push     = (in_valid & (lane == 2'd3)) | in_last;
    n_bytes  = {1'b0, lane} + {2'b00, in_valid};
    be_new   = 4'((5'd1 << n_bytes) - 5'd1);
    raw      = {8'h00, acc};
    if (in_valid) begin
      raw[{lane, 3'b000} +: 8] = ccmpOutDataMux;
    end
    word_in.last = in_last;
    word_in.be   = be_new;
    // Lanes beyond the enabled bytes may hold stale bytes from an
    // earlier frame; zero them.
    for (int i = 0; i < 4; i++) begin
      word_in.data[8*i +: 8] = be_new[i] ? raw[8*i +: 8] : 8'h00;
    end
    full   = (count == CW'(FIFO_DEPTH));
    do_pop = wordValid & wordReady & ~flush_p;
    do_wr  = push & (~full | do_pop);
    drop   = push & full & ~do_pop;
    if (flush_p || push) begin
      lane_nxt = 2'd0;
    end else if (in_valid) begin
      lane_nxt = lane + 2'd1;
    end else begin
      lane_nxt = lane;
    end
    if (flush_p) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(do_wr) - CW'(do_pop);
    end
  end

  always_ff @(posedge macCoreClk or negedge macCoreClkHardRst_n) begin
    if (!macCoreClkHardRst_n) begin
      acc    <= '0;
      lane   <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      idle_q <= 1'b1;
    end else begin
      if (in_valid && lane != 2'd3) begin
        acc[{lane, 3'b000} +: 8] <= ccmpOutDataMux;
      end
      lane   <= lane_nxt;
      count  <= count_nxt;
      idle_q <= (lane_nxt == 2'd0) && (count_nxt == '0);
      if (flush_p) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
      end else begin
        wr_ptr <= wr_ptr + AW'(do_wr);
        rd_ptr <= rd_ptr + AW'(do_pop);
        if (drop) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge macCoreClk) begin
    if (do_wr) begin
      mem[wr_ptr] <= word_in;
    end
  end

  // Head entry gated by occupancy so an empty FIFO presents zeros.
  assign head           = mem[rd_ptr];
  assign wordValid      = (count != '0);
  assign wordData       = wordValid ? head.data : 32'h0;
  assign wordBe         = wordValid ? head.be : 4'h0;
  assign wordLast       = wordValid ? head.last : 1'b0;
  assign packerOverflow = ovf_q;
  assign packerIdle     = idle_q;

endmodule

// File: doc/ccmp_out_packer.md
# ccmp_out_packer

Byte-to-word packer for the CCMP output path. It takes the muxed CCMP output byte stream (data, valid pulse, last pulse) and assembles little-endian 32-bit words with byte enables. The words are buffered in a small FIFO and handed to the MAC RX/TX FIFO writer over a valid/ready handshake. It absorbs writer back-pressure so the CCMP engine never stalls mid-frame, and flags any loss.

## Interface
Parameters:
- FIFO_DEPTH, 4, number of 32-bit word entries; power of two, minimum 2.

Ports:
- macCoreClk  in  1  MAC core clock; all logic on rising edge.
- macCoreClkHardRst_n  in  1  asynchronous active-low reset.
- ccmpOutDataMux  in  8  CCMP output byte.
- ccmpOutValidMux_p  in  1  one-cycle pulse; ccmpOutDataMux valid this cycle.
- ccmpOutLastMux_p  in  1  one-cycle pulse; end of frame (with or without a coincident valid byte).
- flush_p  in  1  synchronous abort; clears accumulator, FIFO, overflow flag.
- wordReady  in  1  downstream accepts wordData this cycle.
- wordData  out  32  packed word; first byte of each group in [7:0].
- wordBe  out  4  byte enables; bit i covers [8i+7:8i].
- wordLast  out  1  word is the final word of the frame.
- wordValid  out  1  FIFO head holds a word.
- packerOverflow  out  1  sticky; a word was dropped because the FIFO was full.
- packerIdle  out  1  accumulator empty and FIFO empty.

## Operation
- Accumulator: 24-bit byte register plus a 2-bit lane pointer (0..3).
  - On each valid byte, the byte is written to lane = pointer, and the pointer increments.
- Push conditions, evaluated each cycle:
  - Full word: valid byte at lane 3 → push {byte, acc[23:0]}, be=1111, last=ccmpOutLastMux_p; pointer resets to 0.
  - Last with valid at lane k<3 → push partial word, be has bits 0..k set, last=1, unused lanes 0; pointer resets to 0.
  - Last without valid, pointer p>0 → push acc, be has bits 0..p-1 set, last=1; pointer resets to 0.
  - Last without valid, pointer 0 → push an empty marker word: data 0, be=0000, last=1.
- FIFO:
  - Circular buffer of FIFO_DEPTH entries × 37 bits (32 data, 4 be, 1 last).
  - Read/write pointers are log2(FIFO_DEPTH) bits wide and wrap naturally.
  - Occupancy count is log2(FIFO_DEPTH)+1 bits wide.
- Pop: when wordValid && wordReady, the read pointer advances.
- Full FIFO, push requested, no pop this cycle:
  - The word is dropped and packerOverflow is set.
  - The accumulator still resets as it would for a normal push.
- Full FIFO, push and pop in the same cycle: both are performed and the count is unchanged.
- Empty FIFO, push and pop in the same cycle: no pop is possible, because wordValid=0.
- flush_p has highest priority:
  - Pointers, count, lane pointer and packerOverflow clear in the same cycle.
  - Any byte or last pulse arriving that cycle is discarded.
- packerOverflow clears only on flush_p or reset.
- Valid bytes arriving after a frame's last pulse start a new frame at lane 0.

## Timing
- Reset values: wordData=0, wordBe=0, wordLast=0, wordValid=0, packerOverflow=0, packerIdle=1; all pointers and counts 0.
- Outputs are driven from the FIFO head register/array entry, with no combinational path from the ccmp* inputs.
- Latency: the byte or last that triggers a push in cycle N gives wordValid=1 in cycle N+1 if the FIFO was empty.
- Throughput:
  - Input accepts one byte per cycle with no back-pressure.
  - Output can pop one word per cycle.
- wordData, wordBe and wordLast hold stable while wordValid=1 and wordReady=0.
- Handshake: wordReady may be asserted at any time; a transfer occurs only on cycles where wordValid=1.
- packerOverflow rises in cycle N+1 after a drop in cycle N.
- packerIdle is registered. It is 1 in cycle N+1 only if, after cycle N's updates, the lane pointer is 0 and the count is 0.
- Reset asserted mid-frame: everything returns to reset values immediately; no partial word is emitted after release.

## Test plan
- Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, last on 0x44, wordReady=1 → one word: 0x44332211, be=1111, last=1, wordValid high one cycle.
- 6 bytes 0x01..0x06, last on 0x06 → words 0x04030201/1111/last=0, then 0x00000605/0011/last=1.
- 4 bytes, then a separate last pulse with no valid → 0x..../1111/last=0, then 0x00000000/0000/last=1.
- wordReady=0, stream 24 bytes (6 full words) with FIFO_DEPTH=4 → 4 words retained, packerOverflow=1; then assert wordReady → exactly the first 4 words are popped, in order.
- FIFO full and the next full word completes in a cycle with wordReady=1 → no drop, packerOverflow stays 0, count stays 4.
- 2 bytes into the accumulator, 1 word in the FIFO, pulse flush_p → wordValid=0, packerIdle=1 next cycle; next 4 bytes yield a word with the first byte at [7:0].
